// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/command widths, the command type and the
// opcode field location used by the fetch/decode pipeline.
package cpu_pkg;

   localparam int unsigned DATA_W  = 14;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned CMD_W   = 2 * DATA_W;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OPC_MSB = CMD_W - 1;

   typedef logic [CMD_W-1:0] cmd_t;
   typedef logic [OPC_W-1:0] opcode_t;

   // Opcode occupies the top OPC_W bits of a command.
   function automatic opcode_t cmd_opcode(input cmd_t cmd);
      return cmd[OPC_MSB -: OPC_W];
   endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// Command storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owner.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from the array)
module cmd_fifo_mem
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = CMD_W,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Show-ahead read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/command_queue.sv
// Command buffer between ROM fetch and decode. Pairs consecutive ROM words
// into commands, queues them in a DEPTH-entry FIFO and produces the fetch
// and decode stall signals.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   rom_data      - ROM word, valid with comm_write
//   comm_write    - fetch delivers a word this cycle
//   comm_read     - decode consumes the head command this cycle
//   flush         - synchronous discard of all buffered state
//   command_in    - head command {first, second}; 0 when empty
//   pause_READ    - fetch must stall (full and a first half is held)
//   pause_DECODE  - decode must stall (queue empty)
//   count         - committed commands in the FIFO
//   overflow      - sticky: a second-half word was dropped
//   underflow     - sticky: read attempted while empty
module command_queue #(
   parameter int unsigned  DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned  DEPTH  = 4,
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
   localparam int unsigned CMD_W  = 2 * DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              comm_write,
   input  logic              comm_read,
   input  logic              flush,
   output logic [CMD_W-1:0]  command_in,
   output logic              pause_READ,
   output logic              pause_DECODE,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] hi_reg;
   logic              half_valid;
   logic [CMD_W-1:0]  rd_data;

   logic empty_c;
   logic full_c;
   logic pop_ok_c;
   logic push_ok_c;
   logic mem_we_c;

   // Push/pop qualification; a full queue still accepts a push when a pop
   // frees the head in the same cycle.
   always_comb begin
      empty_c   = (count == '0);
      full_c    = (count == CNT_W'(DEPTH));
      pop_ok_c  = comm_read && !empty_c;
      push_ok_c = comm_write && half_valid && (!full_c || comm_read);
      mem_we_c  = push_ok_c && !flush;
   end

   // Assembler, pointers, occupancy and sticky flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hi_reg     <= '0;
         half_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         half_valid <= 1'b0;
      end else begin
         if (push_ok_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok_c, pop_ok_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (comm_write) begin
            if (!half_valid) begin
               hi_reg     <= rom_data;
               half_valid <= 1'b1;
            end else if (push_ok_c) begin
               half_valid <= 1'b0;
            end else begin
               // Second half dropped; first half stays held for retry.
               overflow <= 1'b1;
            end
         end
         if (comm_read && empty_c) begin
            underflow <= 1'b1;
         end
      end
   end

   cmd_fifo_mem #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_c),
      .waddr (wr_ptr),
      .wdata ({hi_reg, rom_data}),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign command_in   = empty_c ? '0 : rd_data;
   assign pause_DECODE = empty_c;
   assign pause_READ   = full_c && half_valid;

endmodule

// File: tb/tb_command_queue.sv
// Self-checking bench for command_queue with a queue-based reference model.
module tb_command_queue;

   localparam int unsigned DW    = 14;
   localparam int unsigned CW    = 28;
   localparam int unsigned DEPTH = 4;

   logic          clk;
   logic          reset;
   logic [DW-1:0] rom_data;
   logic          comm_write;
   logic          comm_read;
   logic          flush;
   logic [CW-1:0] command_in;
   logic          pause_READ;
   logic          pause_DECODE;
   logic [2:0]    count;
   logic          overflow;
   logic          underflow;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [CW-1:0] mq[$];
   logic          m_hv;
   logic [DW-1:0] m_hi;
   logic          m_of;
   logic          m_uf;

   command_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_data     (rom_data),
      .comm_write   (comm_write),
      .comm_read    (comm_read),
      .flush        (flush),
      .command_in   (command_in),
      .pause_READ   (pause_READ),
      .pause_DECODE (pause_DECODE),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_hv = 1'b0;
      m_hi = '0;
      m_of = 1'b0;
      m_uf = 1'b0;
   endtask

   // Behaviour of one clock edge, from the queue's rules.
   task automatic model_step(input logic w, input logic [DW-1:0] d,
                             input logic r, input logic f);
      logic popped;
      if (f) begin
         mq.delete();
         m_hv = 1'b0;
      end else begin
         popped = 1'b0;
         if (r) begin
            if (mq.size() > 0) begin
               void'(mq.pop_front());
               popped = 1'b1;
            end else begin
               m_uf = 1'b1;
            end
         end
         if (w) begin
            if (!m_hv) begin
               m_hi = d;
               m_hv = 1'b1;
            end else if (mq.size() < DEPTH || popped) begin
               mq.push_back({m_hi, d});
               m_hv = 1'b0;
            end else begin
               m_of = 1'b1;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, settle past the edge.
   task automatic cycle(input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f);
      comm_write = w;
      rom_data   = d;
      comm_read  = r;
      flush      = f;
      @(posedge clk);
      model_step(w, d, r, f);
      #1;
      comm_write = 1'b0;
      comm_read  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic do_reset();
      comm_write = 1'b0;
      comm_read  = 1'b0;
      flush      = 1'b0;
      rom_data   = '0;
      reset      = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      comm_write = 1'b0;
      comm_read  = 1'b0;
      flush      = 1'b0;
      rom_data   = '0;
      reset      = 1'b0;
      model_reset();
      #12;
      n_total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (command_in !== 28'h0) $display("FAIL reset_cmd: got %0h expected 0", command_in); else n_pass++;
      n_total++; if (pause_DECODE !== 1'b1) $display("FAIL reset_pause_decode: got %0b expected 1", pause_DECODE); else n_pass++;
      n_total++; if (pause_READ !== 1'b0) $display("FAIL reset_pause_read: got %0b expected 0", pause_READ); else n_pass++;
      n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags: got %0b expected 00", {overflow, underflow}); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      cycle(1'b1, 14'h0A5, 1'b0, 1'b0);
      n_total++; if (count !== 3'd0) $display("FAIL basic_half_count: got %0d expected 0", count); else n_pass++;
      cycle(1'b1, 14'h1F3, 1'b0, 1'b0);
      n_total++; if (count !== 3'd1) $display("FAIL basic_count: got %0d expected 1", count); else n_pass++;
      n_total++; if (pause_DECODE !== 1'b0) $display("FAIL basic_pause_decode: got %0b expected 0", pause_DECODE); else n_pass++;
      n_total++; if (command_in !== 28'h02941F3) $display("FAIL basic_cmd: got %0h expected 2941f3", command_in); else n_pass++;
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (count !== 3'd0) $display("FAIL basic_pop_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (command_in !== 28'h0) $display("FAIL basic_pop_cmd: got %0h expected 0", command_in); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] a, b;
      logic [CW-1:0] first;
      do_reset();
      first = '0;
      for (int i = 0; i < 4; i++) begin
         a = DW'($urandom);
         b = DW'($urandom);
         if (i == 0) first = {a, b};
         cycle(1'b1, a, 1'b0, 1'b0);
         cycle(1'b1, b, 1'b0, 1'b0);
      end
      n_total++; if (count !== 3'd4) $display("FAIL ovf_fill_count: got %0d expected 4", count); else n_pass++;
      n_total++; if (pause_READ !== 1'b0) $display("FAIL ovf_full_no_half: got %0b expected 0", pause_READ); else n_pass++;
      cycle(1'b1, 14'h111, 1'b0, 1'b0);
      n_total++; if (pause_READ !== 1'b1) $display("FAIL ovf_pause_read: got %0b expected 1", pause_READ); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %0b expected 0", overflow); else n_pass++;
      cycle(1'b1, 14'h0AB, 1'b0, 1'b0);
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow); else n_pass++;
      n_total++; if (count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", count); else n_pass++;
      n_total++; if (pause_READ !== 1'b1) $display("FAIL ovf_half_kept: got %0b expected 1", pause_READ); else n_pass++;
      n_total++; if (command_in !== first) $display("FAIL ovf_head: got %0h expected %0h", command_in, first); else n_pass++;
   endtask

   task automatic test_simul();
      logic [DW-1:0] a, b;
      logic [CW-1:0] c[5];
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = DW'($urandom);
         b = DW'($urandom);
         c[i] = {a, b};
         cycle(1'b1, a, 1'b0, 1'b0);
         cycle(1'b1, b, 1'b0, 1'b0);
      end
      c[4] = {14'h2AA, 14'h155};
      cycle(1'b1, 14'h2AA, 1'b0, 1'b0);
      cycle(1'b1, 14'h155, 1'b1, 1'b0);
      n_total++; if (count !== 3'd4) $display("FAIL simul_count: got %0d expected 4", count); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL simul_overflow: got %0b expected 0", overflow); else n_pass++;
      n_total++; if (pause_READ !== 1'b0) $display("FAIL simul_pause_read: got %0b expected 0", pause_READ); else n_pass++;
      for (int i = 1; i < 5; i++) begin
         n_total++; if (command_in !== c[i]) $display("FAIL simul_drain%0d: got %0h expected %0h", i, command_in, c[i]); else n_pass++;
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      n_total++; if (count !== 3'd0) $display("FAIL simul_empty: got %0d expected 0", count); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [DW-1:0] a, b;
      logic [CW-1:0] exp_cmd[6];
      int k;
      do_reset();
      k = 0;
      for (int i = 0; i < 6; i++) begin
         a = DW'($urandom);
         b = DW'($urandom);
         exp_cmd[i] = {a, b};
         if (i >= 2) begin
            n_total++; if (command_in !== exp_cmd[k]) $display("FAIL wrap_pop%0d: got %0h expected %0h", k, command_in, exp_cmd[k]); else n_pass++;
            cycle(1'b1, a, 1'b1, 1'b0);
            k++;
         end else begin
            cycle(1'b1, a, 1'b0, 1'b0);
         end
         cycle(1'b1, b, 1'b0, 1'b0);
      end
      n_total++; if (count !== 3'd2) $display("FAIL wrap_mid_count: got %0d expected 2", count); else n_pass++;
      for (int j = 4; j < 6; j++) begin
         n_total++; if (command_in !== exp_cmd[j]) $display("FAIL wrap_pop%0d: got %0h expected %0h", j, command_in, exp_cmd[j]); else n_pass++;
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      n_total++; if (count !== 3'd0) $display("FAIL wrap_end_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (pause_DECODE !== 1'b1) $display("FAIL wrap_end_pause: got %0b expected 1", pause_DECODE); else n_pass++;
   endtask

   task automatic test_underflow_flush();
      do_reset();
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (underflow !== 1'b1) $display("FAIL uf_flag: got %0b expected 1", underflow); else n_pass++;
      n_total++; if (count !== 3'd0) $display("FAIL uf_count: got %0d expected 0", count); else n_pass++;
      for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      n_total++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count); else n_pass++;
      cycle(1'b1, 14'h3FF, 1'b1, 1'b1);
      n_total++; if (count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (pause_DECODE !== 1'b1) $display("FAIL flush_pause_decode: got %0b expected 1", pause_DECODE); else n_pass++;
      n_total++; if (underflow !== 1'b1) $display("FAIL flush_sticky_uf: got %0b expected 1", underflow); else n_pass++;
      // Held half must be gone: the next two words form a fresh command.
      cycle(1'b1, 14'h012, 1'b0, 1'b0);
      cycle(1'b1, 14'h345, 1'b0, 1'b0);
      n_total++; if (count !== 3'd1) $display("FAIL flush_hv_count: got %0d expected 1", count); else n_pass++;
      n_total++; if (command_in !== {14'h012, 14'h345}) $display("FAIL flush_hv_cmd: got %0h expected %0h", command_in, {14'h012, 14'h345}); else n_pass++;
   endtask

   task automatic test_random();
      logic          w, r, f;
      logic [CW-1:0] e_cmd;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 40) == 0);
         cycle(w, DW'($urandom), r, f);
         e_cmd = (mq.size() > 0) ? mq[0] : '0;
         n_total++; if (count !== 3'(mq.size())) $display("FAIL rnd_count@%0d: got %0d expected %0d", i, count, mq.size()); else n_pass++;
         n_total++; if (command_in !== e_cmd) $display("FAIL rnd_cmd@%0d: got %0h expected %0h", i, command_in, e_cmd); else n_pass++;
         n_total++; if (pause_DECODE !== (mq.size() == 0)) $display("FAIL rnd_pause_decode@%0d: got %0b", i, pause_DECODE); else n_pass++;
         n_total++; if (pause_READ !== (mq.size() == DEPTH && m_hv)) $display("FAIL rnd_pause_read@%0d: got %0b", i, pause_READ); else n_pass++;
         n_total++; if ({overflow, underflow} !== {m_of, m_uf}) $display("FAIL rnd_flags@%0d: got %0b expected %0b", i, {overflow, underflow}, {m_of, m_uf}); else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      n_total++; if (count !== 3'd2) $display("FAIL arst_pre_count: got %0d expected 2", count); else n_pass++;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_total++; if (count !== 3'd0) $display("FAIL arst_count: got %0d expected 0", count); else n_pass++;
      n_total++; if (command_in !== 28'h0) $display("FAIL arst_cmd: got %0h expected 0", command_in); else n_pass++;
      n_total++; if (pause_DECODE !== 1'b1) $display("FAIL arst_pause_decode: got %0b expected 1", pause_DECODE); else n_pass++;
      n_total++; if (pause_READ !== 1'b0) $display("FAIL arst_pause_read: got %0b expected 0", pause_READ); else n_pass++;
      n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL arst_flags: got %0b expected 00", {overflow, underflow}); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      cycle(1'b1, 14'h2BC, 1'b0, 1'b0);
      cycle(1'b1, 14'h0DE, 1'b0, 1'b0);
      n_total++; if (command_in !== {14'h2BC, 14'h0DE}) $display("FAIL arst_no_partial: got %0h expected %0h", command_in, {14'h2BC, 14'h0DE}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_simul();
      test_wrap();
      test_underflow_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
